// File: rtl/leds_ctrl_pkg.sv
// Shared mode encoding and default sizing for the LED PWM/blink controller.
package leds_ctrl_pkg;
  localparam int N_LEDS_DEF     = 16;
  localparam int PWM_BITS_DEF   = 8;
  localparam int BLINK_BITS_DEF = 24;

  typedef enum logic [1:0] {
    MODE_STATIC    = 2'd0,
    MODE_BLINK     = 2'd1,
    MODE_DIM       = 2'd2,
    MODE_BLINK_DIM = 2'd3
  } mode_e;
endpackage

// File: rtl/leds_pwm_ctrl_if.sv
// Load/acknowledge bus between the accelerator and the LED controller.
interface leds_pwm_ctrl_if
  import leds_ctrl_pkg::*;
#(
  parameter int N_LEDS     = N_LEDS_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int BLINK_BITS = BLINK_BITS_DEF
) ();
  logic                  start_port;
  logic [N_LEDS-1:0]     val;
  logic [1:0]            mode;
  logic [PWM_BITS-1:0]   duty;
  logic [BLINK_BITS-1:0] blink_half;
  logic                  done_port;
  logic [N_LEDS-1:0]     leds;

  modport master (output start_port, val, mode, duty, blink_half,
                  input  done_port, leds);
  modport slave  (input  start_port, val, mode, duty, blink_half,
                  output done_port, leds);
endinterface

// File: rtl/leds_blink_timer.sv
// Blink half-period timer; phase toggles every `half` cycles, half=0 means always on.
module leds_blink_timer
  import leds_ctrl_pkg::*;
#(
  parameter int BLINK_BITS = BLINK_BITS_DEF
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  restart,
  input  logic [BLINK_BITS-1:0] half,
  output logic                  phase
);
  localparam logic [BLINK_BITS-1:0] ONE = BLINK_BITS'(1);

  logic [BLINK_BITS-1:0] cnt_q, cnt_d;
  logic                  phase_q, phase_d;

  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    // Restart and the no-blink case both park the timer at the start of an on-phase.
    if (restart || half == '0) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == half - ONE) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + ONE;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      cnt_q   <= '0;
      phase_q <= 1'b1;
    end else begin
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
    end
  end

  assign phase = phase_q;
endmodule

// File: rtl/leds_pwm_ctrl.sv
// LED driver: static / blink / PWM-dim / blink+dim, reconfigured by a start strobe.
module leds_pwm_ctrl
  import leds_ctrl_pkg::*;
#(
  parameter int N_LEDS     = N_LEDS_DEF,
  parameter int PWM_BITS   = PWM_BITS_DEF,
  parameter int BLINK_BITS = BLINK_BITS_DEF
) (
  input logic              clock,
  input logic              reset,
  leds_pwm_ctrl_if.slave   bus
);
  localparam logic [PWM_BITS-1:0] PWM_ONE = PWM_BITS'(1);

  logic [N_LEDS-1:0]     val_q,  val_d;
  logic [1:0]            mode_q, mode_d;
  logic [PWM_BITS-1:0]   duty_q, duty_d;
  logic [BLINK_BITS-1:0] half_q, half_d;
  logic [PWM_BITS-1:0]   pwm_cnt_q, pwm_cnt_d;
  logic                  done_q, done_d;
  logic [N_LEDS-1:0]     leds_q, leds_d;
  logic                  load, phase, pwm_on, gate;

  assign load = bus.start_port;

  leds_blink_timer #(.BLINK_BITS(BLINK_BITS)) u_blink (
    .clock   (clock),
    .reset   (reset),
    .restart (load),
    .half    (half_q),
    .phase   (phase)
  );

  // Full-scale duty must never blank, so it bypasses the compare.
  assign pwm_on = (duty_q == '1) || (pwm_cnt_q < duty_q);

  always_comb begin
    val_d     = val_q;
    mode_d    = mode_q;
    duty_d    = duty_q;
    half_d    = half_q;
    pwm_cnt_d = pwm_cnt_q + PWM_ONE;
    done_d    = load;
    if (load) begin
      val_d     = bus.val;
      mode_d    = bus.mode;
      duty_d    = bus.duty;
      half_d    = bus.blink_half;
      pwm_cnt_d = '0;
    end
    gate = 1'b1;
    case (mode_e'(mode_q))
      MODE_STATIC:    gate = 1'b1;
      MODE_BLINK:     gate = phase;
      MODE_DIM:       gate = pwm_on;
      MODE_BLINK_DIM: gate = phase & pwm_on;
      default:        gate = 1'b1;
    endcase
    leds_d = val_q & {N_LEDS{gate}};
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      val_q     <= '0;
      mode_q    <= '0;
      duty_q    <= '0;
      half_q    <= '0;
      pwm_cnt_q <= '0;
      done_q    <= 1'b0;
      leds_q    <= '0;
    end else begin
      val_q     <= val_d;
      mode_q    <= mode_d;
      duty_q    <= duty_d;
      half_q    <= half_d;
      pwm_cnt_q <= pwm_cnt_d;
      done_q    <= done_d;
      leds_q    <= leds_d;
    end
  end

  assign bus.done_port = done_q;
  assign bus.leds      = leds_q;
endmodule
